// File: rtl/alu_exec_unit.sv
// Execution unit: single-cycle logic/add/shift ops plus a multi-cycle unsigned
// shift-add multiplier, with registered Result/Zero/Overflow and a Done pulse.
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       AluControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Done,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        count_reg, count_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
    logic [WIDTH-1:0]     mplier_reg, mplier_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    logic                 zero_reg, zero_next;
    logic                 overflow_reg, overflow_next;
    logic                 done_reg, done_next;

    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ov;
    logic [2*WIDTH-1:0]   acc_sum;

    // Single-cycle datapath; unused codes fall through to zero.
    always_comb begin
        sum     = A + B;
        diff    = A - B;
        alu_res = '0;
        alu_ov  = 1'b0;
        case (AluControl)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_ADD, OP_ADDI: begin
                alu_res = sum;
                alu_ov  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ov  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLL:  alu_res = A << B[SHW-1:0];
            OP_SRL:  alu_res = A >> B[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        acc_next      = acc_reg;
        mcand_next    = mcand_reg;
        mplier_next   = mplier_reg;
        result_next   = result_reg;
        zero_next     = zero_reg;
        overflow_next = overflow_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    if (AluControl == OP_MUL) begin
                        mcand_next  = {{WIDTH{1'b0}}, A};
                        mplier_next = B;
                        acc_next    = '0;
                        count_next  = CW'(WIDTH);
                        state_next  = MUL;
                    end else begin
                        result_next   = alu_res;
                        zero_next     = (alu_res == '0);
                        overflow_next = alu_ov;
                        done_next     = 1'b1;
                    end
                end
            end
            MUL: begin
                // Operands were latched on entry, so Start/A/B/AluControl are ignored here.
                acc_next    = acc_sum;
                mplier_next = mplier_reg >> 1;
                mcand_next  = mcand_reg << 1;
                count_next  = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    result_next   = acc_sum[WIDTH-1:0];
                    zero_next     = (acc_sum[WIDTH-1:0] == '0);
                    overflow_next = |acc_sum[2*WIDTH-1:WIDTH];
                    done_next     = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            result_reg   <= '0;
            zero_reg     <= 1'b1;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            acc_reg      <= acc_next;
            mcand_reg    <= mcand_next;
            mplier_reg   <= mplier_next;
            result_reg   <= result_next;
            zero_reg     <= zero_next;
            overflow_reg <= overflow_next;
            done_reg     <= done_next;
        end
    end

    assign Result   = result_reg;
    assign Zero     = zero_reg;
    assign Overflow = overflow_reg;
    assign Done     = done_reg;
    assign Busy     = (state_reg == MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [3:0]  AluControl;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        Done;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    alu_exec_unit #(.WIDTH(16), .SHW(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .AluControl (AluControl),
        .A          (A),
        .B          (B),
        .Result     (Result),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .Done       (Done),
        .Busy       (Busy)
    );

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic void ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output logic ov);
        int s;
        logic [31:0] p;
        r  = 16'h0;
        ov = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0010: r = a | b;
            4'b0011: r = a ^ b;
            4'b0100, 4'b0101: begin
                s  = int'($signed(a)) + int'($signed(b));
                r  = a + b;
                ov = (s > 32767) || (s < -32768);
            end
            4'b1100: begin
                s  = int'($signed(a)) - int'($signed(b));
                r  = a - b;
                ov = (s > 32767) || (s < -32768);
            end
            4'b0001: r = a << b[3:0];
            4'b0110: r = a >> b[3:0];
            4'b0111: begin
                p  = {16'h0, a} * {16'h0, b};
                r  = p[15:0];
                ov = (p > 32'h0000_FFFF);
            end
            default: r = 16'h0;
        endcase
    endfunction

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; AluControl = 4'h0; A = 16'h0; B = 16'h0;
        #1;
        n_cmp++;
        if ({Result, Zero, Overflow, Done, Busy} !== {16'h0, 4'b1000}) begin
            n_err++;
            $display("FAIL reset_async: got R=%h Z=%b V=%b D=%b B=%b, want R=0000 Z=1 V=0 D=0 B=0",
                     Result, Zero, Overflow, Done, Busy);
        end
        @(posedge Clock); @(posedge Clock); #1;
        Reset = 1'b0;
        @(posedge Clock); #1;
        n_cmp++;
        if ({Result, Zero, Overflow, Done, Busy} !== {16'h0, 4'b1000}) begin
            n_err++;
            $display("FAIL reset_hold: got R=%h Z=%b V=%b D=%b B=%b, want R=0000 Z=1 V=0 D=0 B=0",
                     Result, Zero, Overflow, Done, Busy);
        end
        $display("reset: R=%h Z=%b V=%b D=%b B=%b", Result, Zero, Overflow, Done, Busy);
    endtask

    task automatic test_directed();
        logic [3:0]  ops [5] = '{4'b0100, 4'b1100, 4'b0001, 4'b0110, 4'b1111};
        logic [15:0] as  [5] = '{16'h7FFF, 16'h1234, 16'h0001, 16'h8000, 16'hABCD};
        logic [15:0] bs  [5] = '{16'h0001, 16'h1234, 16'h000F, 16'h0003, 16'h1357};
        logic [15:0] ers [5] = '{16'h8000, 16'h0000, 16'h8000, 16'h1000, 16'h0000};
        logic        eos [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            AluControl = ops[i]; A = as[i]; B = bs[i]; Start = 1'b1;
            @(posedge Clock); #1;
            Start = 1'b0;
            n_cmp++;
            if ({Result, Zero, Overflow, Done} !== {ers[i], (ers[i] == 16'h0), eos[i], 1'b1}) begin
                n_err++;
                $display("FAIL directed_%0d: got R=%h Z=%b V=%b D=%b, want R=%h Z=%b V=%b D=1",
                         i, Result, Zero, Overflow, Done, ers[i], (ers[i] == 16'h0), eos[i]);
            end
            $display("directed op=%b A=%h B=%h -> R=%h Z=%b V=%b D=%b", ops[i], as[i], bs[i],
                     Result, Zero, Overflow, Done);
            @(posedge Clock); #1;
            n_cmp++;
            if (Done !== 1'b0 || Result !== ers[i]) begin
                n_err++;
                $display("FAIL directed_hold_%0d: got D=%b R=%h, want D=0 R=%h", i, Done, Result, ers[i]);
            end
        end
    endtask

    task automatic test_random_ops();
        logic [15:0] er, held;
        logic        eo;
        held = Result;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                Start = 1'b0; AluControl = 4'($urandom_range(0, 15)); A = 16'($urandom); B = 16'($urandom);
                @(posedge Clock); #1;
                n_cmp++;
                if (Done !== 1'b0 || Result !== held) begin
                    n_err++;
                    $display("FAIL idle_hold_%0d: got D=%b R=%h, want D=0 R=%h", i, Done, Result, held);
                end
            end else begin
                AluControl = 4'($urandom_range(0, 15));
                if (AluControl == 4'b0111) AluControl = 4'b0011;
                A = 16'($urandom); B = 16'($urandom);
                if ($urandom_range(0, 4) == 0) B = A;
                ref_model(AluControl, A, B, er, eo);
                Start = 1'b1;
                @(posedge Clock); #1;
                Start = 1'b0;
                n_cmp++;
                if ({Result, Zero, Overflow, Done} !== {er, (er == 16'h0), eo, 1'b1}) begin
                    n_err++;
                    $display("FAIL random_%0d: op=%b A=%h B=%h got R=%h Z=%b V=%b D=%b, want R=%h Z=%b V=%b D=1",
                             i, AluControl, A, B, Result, Zero, Overflow, Done, er, (er == 16'h0), eo);
                end
                $display("random op=%b A=%h B=%h -> R=%h Z=%b V=%b", AluControl, A, B, Result, Zero, Overflow);
                held = er;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] er;
        logic        eo;
        for (int i = 0; i < 8; i++) begin
            AluControl = (i % 2 == 0) ? 4'b0100 : 4'b1100;
            A = 16'($urandom); B = 16'($urandom);
            ref_model(AluControl, A, B, er, eo);
            Start = 1'b1;
            @(posedge Clock); #1;
            n_cmp++;
            if ({Result, Overflow, Done} !== {er, eo, 1'b1}) begin
                n_err++;
                $display("FAIL b2b_%0d: got R=%h V=%b D=%b, want R=%h V=%b D=1", i, Result, Overflow, Done, er, eo);
            end
            $display("b2b op=%b A=%h B=%h -> R=%h V=%b D=%b", AluControl, A, B, Result, Overflow, Done);
        end
        Start = 1'b0;
        @(posedge Clock); #1;
        n_cmp++;
        if (Done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got D=%b, want D=0", Done);
        end
    endtask

    task automatic test_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                            input logic eo, input bit perturb);
        int n;
        bit busy_ok;
        AluControl = 4'b0111; A = a; B = b; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (n < 40) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            if (perturb) begin
                Start = 1'($urandom_range(0, 1)); AluControl = 4'b0000;
                A = 16'($urandom); B = 16'($urandom);
            end
            @(posedge Clock); #1;
            n++;
            if (Done === 1'b1) break;
        end
        Start = 1'b0;
        n_cmp++;
        if (n != 16 || !busy_ok) begin
            n_err++;
            $display("FAIL mul_latency: got %0d cycles busy_ok=%b, want 16 cycles busy_ok=1", n, busy_ok);
        end
        n_cmp++;
        if ({Result, Zero, Overflow, Done, Busy} !== {er, (er == 16'h0), eo, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL mul_result: A=%h B=%h got R=%h Z=%b V=%b D=%b B=%b, want R=%h Z=%b V=%b D=1 B=0",
                     a, b, Result, Zero, Overflow, Done, Busy, er, (er == 16'h0), eo);
        end
        $display("mul A=%h B=%h perturb=%0d -> R=%h Z=%b V=%b after %0d cycles", a, b, perturb,
                 Result, Zero, Overflow, n);
        @(posedge Clock); #1;
        n_cmp++;
        if (Done !== 1'b0 || Result !== er) begin
            n_err++;
            $display("FAIL mul_single_done: got D=%b R=%h, want D=0 R=%h", Done, Result, er);
        end
    endtask

    task automatic test_random_mul();
        logic [15:0] a, b, er;
        logic        eo;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            if (i < 3) begin a = a & 16'h00FF; b = b & 16'h00FF; end
            ref_model(4'b0111, a, b, er, eo);
            test_mul(a, b, er, eo, 1'(i % 2));
        end
    endtask

    task automatic test_reset_mid_mul();
        int dones;
        AluControl = 4'b0010; A = 16'h1234; B = 16'h0000; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        n_cmp++;
        if (Result !== 16'h1234) begin
            n_err++;
            $display("FAIL pre_reset_or: got R=%h, want R=1234", Result);
        end
        AluControl = 4'b0111; A = 16'h0012; B = 16'h0034; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (7) begin @(posedge Clock); #1; end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({Result, Zero, Overflow, Done, Busy} !== {16'h0, 4'b1000}) begin
            n_err++;
            $display("FAIL reset_mid_mul: got R=%h Z=%b V=%b D=%b B=%b, want R=0000 Z=1 V=0 D=0 B=0",
                     Result, Zero, Overflow, Done, Busy);
        end
        $display("reset mid-mul: R=%h Z=%b V=%b D=%b B=%b", Result, Zero, Overflow, Done, Busy);
        @(posedge Clock); #1;
        Reset = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge Clock); #1;
            if (Done !== 1'b0 || Busy !== 1'b0) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL no_done_after_abort: got %0d cycles with Done/Busy high, want 0", dones);
        end
        AluControl = 4'b0011; A = 16'h00FF; B = 16'h0F0F; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        n_cmp++;
        if ({Result, Zero, Overflow, Done} !== {16'h0FF0, 3'b001}) begin
            n_err++;
            $display("FAIL xor_after_reset: got R=%h Z=%b V=%b D=%b, want R=0ff0 Z=0 V=0 D=1",
                     Result, Zero, Overflow, Done);
        end
        $display("xor after reset: R=%h D=%b", Result, Done);
    endtask

    task automatic test_mul_then_op();
        AluControl = 4'b0111; A = 16'h0003; B = 16'h0005; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (15) begin @(posedge Clock); #1; end
        n_cmp++;
        if (Done !== 1'b0 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL mul_edge15: got D=%b B=%b, want D=0 B=1", Done, Busy);
        end
        @(posedge Clock); #1;
        n_cmp++;
        if ({Result, Done, Busy} !== {16'h000F, 2'b10}) begin
            n_err++;
            $display("FAIL mul_edge16: got R=%h D=%b B=%b, want R=000f D=1 B=0", Result, Done, Busy);
        end
        AluControl = 4'b0000; A = 16'hF0F0; B = 16'h3C3C; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        n_cmp++;
        if ({Result, Done} !== {16'h3030, 1'b1}) begin
            n_err++;
            $display("FAIL op_after_mul: got R=%h D=%b, want R=3030 D=1", Result, Done);
        end
        $display("and right after mul: R=%h D=%b", Result, Done);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random_ops();
        test_back_to_back();
        test_mul(16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0);
        test_mul(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
        test_mul(16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b1);
        test_random_mul();
        test_mul_then_op();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SHW, default 4, shift-amount width (log2 WIDTH).
REQ-003 SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  operation request, sampled on Clock rising edge.
REQ-006 SHALL have port AluControl  input  4  operation code from ALU control decoder.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B; B[SHW-1:0] is the shift amount for shifts.
REQ-009 SHALL have port Result  output  WIDTH  registered result.
REQ-010 SHALL have port Zero  output  1  registered, high when Result == 0.
REQ-011 SHALL have port Overflow  output  1  registered overflow flag.
REQ-012 SHALL have port Done  output  1  one-cycle pulse, Result/Zero/Overflow just updated.
REQ-013 SHALL have port Busy  output  1  high while a multiply is in progress.

Function
REQ-014 SHALL decode AluControl: 0000 AND, 0010 OR, 0011 XOR, 0100 ADD, 0101 ADD (immediate), 1100 SUB (A-B), 0001 SLL A by B[SHW-1:0], 0110 SRL (logical) A by B[SHW-1:0], 0111 MUL; any other code yields Result 0, Overflow 0.
REQ-015 SHALL implement states IDLE and MUL; Busy = 1 exactly when state is MUL.
REQ-016 SHALL accept Start only in IDLE; Start while Busy SHALL be ignored, with no effect on state or outputs.
REQ-017 Non-MUL op accepted at edge N SHALL update Result/Zero/Overflow at edge N and assert Done during cycle N..N+1 (latency 1).
REQ-018 MUL accepted at edge N SHALL latch A, B, clear a 2*WIDTH accumulator, load counter = WIDTH, enter MUL.
REQ-019 Each MUL cycle SHALL add shifted multiplicand to accumulator when multiplier LSB is 1, shift multiplier right, shift multiplicand left, decrement counter (unsigned shift-add).
REQ-020 On the edge where counter reaches 0 (edge N+WIDTH), SHALL write Result = accumulator[WIDTH-1:0], Overflow = |accumulator[2*WIDTH-1:WIDTH], pulse Done, return to IDLE.
REQ-021 ADD/ADD-imm/SUB Overflow SHALL be signed two's-complement overflow; logic and shift ops SHALL set Overflow 0.
REQ-022 Arithmetic SHALL wrap modulo 2^WIDTH; shift amounts 0..WIDTH-1 only (B upper bits ignored).
REQ-023 Result, Zero, Overflow SHALL hold their value between Done pulses.
REQ-024 Start asserted in the same cycle Busy falls (IDLE) SHALL be accepted; back-to-back single-cycle ops SHALL give Done on consecutive cycles.
REQ-025 Operand/AluControl changes during MUL SHALL not affect the product.
REQ-026 Done SHALL never be high for two cycles for one operation.

Reset
REQ-027 Reset high SHALL immediately force state IDLE, Result 0, Zero 1, Overflow 0, Done 0, Busy 0, counter 0, accumulator 0.
REQ-028 Reset mid-multiply SHALL abort it with no Done pulse; first Start after Reset deasserts SHALL be accepted normally.

Verification
REQ-029 ADD 0100, A=0x7FFF, B=0x0001, Start -> next cycle Result 0x8000, Overflow 1, Zero 0, Done 1 for one cycle.
REQ-030 SUB 1100, A=0x1234, B=0x1234 -> Result 0x0000, Zero 1, Overflow 0; SLL 0001 A=0x0001 B=0x000F -> 0x8000; SRL 0110 A=0x8000 B=0x0003 -> 0x1000.
REQ-031 MUL 0111, A=0x0012, B=0x0034 -> Busy high 16 cycles, Done at edge 16 after Start, Result 0x03A8, Overflow 0; A=0x0100, B=0x0100 -> Result 0x0000, Overflow 1, Zero 1.
REQ-032 During MUL, Start with AND 0000 pulsed and A/B changed -> ignored; MUL result unchanged, single Done.
REQ-033 Reset asserted at cycle 8 of MUL -> outputs at reset values asynchronously, no Done; subsequent XOR 0011 A=0x00FF B=0x0F0F -> Result 0x0FF0.
REQ-034 Unused code 1111 with Start -> Result 0, Zero 1, Overflow 0, Done pulse.
